// File: rtl/conv_tile_scheduler_if.sv
// rtl/conv_tile_scheduler_if.sv - command, memory and engine signal bundle for conv_tile_scheduler
interface conv_tile_scheduler_if #(
  parameter int ADDR_W = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_W-1:0]     cmd_in_base;
  logic [ADDR_W-1:0]     cmd_k_base;
  logic [ADDR_W-1:0]     cmd_out_base;
  logic                  abort;
  logic                  busy;
  logic                  job_done;
  logic                  rd_en;
  logic [ADDR_W-1:0]     rd_addr;
  logic [7:0]            rd_data;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [15:0]           wr_data;
  logic                  conv_rst_n;
  logic                  conv_start;
  logic [35:0][7:0]      conv_tile;
  logic [8:0][7:0]       conv_kernel;
  logic [15:0][15:0]     conv_c;
  logic                  conv_done;

  modport master (
    input  cmd_valid, cmd_in_base, cmd_k_base, cmd_out_base, abort, rd_data, conv_c, conv_done,
    output cmd_ready, busy, job_done, rd_en, rd_addr, wr_en, wr_addr, wr_data,
           conv_rst_n, conv_start, conv_tile, conv_kernel
  );

  modport slave (
    output cmd_valid, cmd_in_base, cmd_k_base, cmd_out_base, abort, rd_data, conv_c, conv_done,
    input  cmd_ready, busy, job_done, rd_en, rd_addr, wr_en, wr_addr, wr_data,
           conv_rst_n, conv_start, conv_tile, conv_kernel
  );
endinterface

// File: rtl/conv_tile_scheduler.sv
// rtl/conv_tile_scheduler.sv - walks stride-4 6x6 tiles of a feature map through the 4x4 conv engine
module conv_tile_scheduler #(
  parameter int IMG_W  = 10,
  parameter int IMG_H  = 10,
  parameter int ADDR_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  conv_tile_scheduler_if.master bus
);
  localparam int OUT_W = IMG_W - 2;
  localparam int TX_N  = OUT_W / 4;
  localparam int TY_N  = (IMG_H - 2) / 4;
  localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] OUT_W_A = ADDR_W'(OUT_W);
  localparam logic [ADDR_W-1:0] TX_LAST = ADDR_W'(TX_N - 1);
  localparam logic [ADDR_W-1:0] TY_LAST = ADDR_W'(TY_N - 1);
  localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_K, S_LOAD_T, S_START, S_WAIT, S_STORE, S_FINISH
  } state_t;

  state_t            state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [2:0]        row_q, row_d, col_q, col_d;
  logic [ADDR_W-1:0] tx_q, tx_d, ty_q, ty_d;
  logic [ADDR_W-1:0] in_base_q, in_base_d, k_base_q, k_base_d, out_base_q, out_base_d;
  logic [35:0][7:0]  tile_q, tile_d;
  logic [8:0][7:0]   kernel_q, kernel_d;
  logic              conv_rst_n_q, conv_rst_n_d;
  logic [5:0]        idx;
  logic [ADDR_W-1:0] tile_y, tile_x;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      tx_q         <= '0;
      ty_q         <= '0;
      in_base_q    <= '0;
      k_base_q     <= '0;
      out_base_q   <= '0;
      tile_q       <= '0;
      kernel_q     <= '0;
      conv_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      row_q        <= row_d;
      col_q        <= col_d;
      tx_q         <= tx_d;
      ty_q         <= ty_d;
      in_base_q    <= in_base_d;
      k_base_q     <= k_base_d;
      out_base_q   <= out_base_d;
      tile_q       <= tile_d;
      kernel_q     <= kernel_d;
      conv_rst_n_q <= conv_rst_n_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    row_d      = row_q;
    col_d      = col_q;
    tx_d       = tx_q;
    ty_d       = ty_q;
    in_base_d  = in_base_q;
    k_base_d   = k_base_q;
    out_base_d = out_base_q;
    tile_d     = tile_q;
    kernel_d   = kernel_q;
    idx        = cnt_q - 6'd1;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          in_base_d  = bus.cmd_in_base;
          k_base_d   = bus.cmd_k_base;
          out_base_d = bus.cmd_out_base;
          tx_d       = '0;
          ty_d       = '0;
          cnt_d      = '0;
          state_d    = S_LOAD_K;
        end
      end
      S_LOAD_K: begin
        // read data trails its strobe by one cycle, so slot cnt-1 is captured
        if (cnt_q != 6'd0) kernel_d[idx[3:0]] = bus.rd_data;
        if (cnt_q == 6'd9) begin
          cnt_d   = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = S_LOAD_T;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_LOAD_T: begin
        if (cnt_q != 6'd0) tile_d[idx] = bus.rd_data;
        if (cnt_q == 6'd36) begin
          cnt_d   = '0;
          state_d = S_START;
        end else begin
          cnt_d = cnt_q + 6'd1;
          if (col_q == 3'd5) begin
            col_d = '0;
            row_d = row_q + 3'd1;
          end else begin
            col_d = col_q + 3'd1;
          end
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.conv_done) begin
          cnt_d   = '0;
          state_d = S_STORE;
        end
      end
      S_STORE: begin
        if (cnt_q == 6'd15) begin
          cnt_d = '0;
          row_d = '0;
          col_d = '0;
          if (tx_q == TX_LAST) begin
            tx_d = '0;
            if (ty_q == TY_LAST) begin
              state_d = S_FINISH;
            end else begin
              ty_d    = ty_q + ONE;
              state_d = S_LOAD_T;
            end
          end else begin
            tx_d    = tx_q + ONE;
            state_d = S_LOAD_T;
          end
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (bus.abort && state_q != S_IDLE) state_d = S_IDLE;
    // engine runs only between its start pulse and the end of the result drain
    conv_rst_n_d = (state_d == S_START) || (state_d == S_WAIT) || (state_d == S_STORE);
  end

  assign tile_y = ty_q << 2;
  assign tile_x = tx_q << 2;

  always_comb begin
    bus.rd_en   = ((state_q == S_LOAD_K) && (cnt_q < 6'd9)) ||
                  ((state_q == S_LOAD_T) && (cnt_q < 6'd36));
    bus.rd_addr = '0;
    if (state_q == S_LOAD_K && bus.rd_en)
      bus.rd_addr = k_base_q + ADDR_W'(cnt_q);
    else if (bus.rd_en)
      bus.rd_addr = in_base_q + (tile_y + ADDR_W'(row_q)) * IMG_W_A + tile_x + ADDR_W'(col_q);
    bus.wr_en   = (state_q == S_STORE);
    bus.wr_addr = '0;
    bus.wr_data = '0;
    if (bus.wr_en) begin
      bus.wr_addr = out_base_q + (tile_y + ADDR_W'(cnt_q[3:2])) * OUT_W_A + tile_x + ADDR_W'(cnt_q[1:0]);
      bus.wr_data = bus.conv_c[cnt_q[3:0]];
    end
  end

  assign bus.cmd_ready   = (state_q == S_IDLE) && !rst;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.job_done    = (state_q == S_FINISH) && !bus.abort;
  assign bus.conv_start  = (state_q == S_START);
  assign bus.conv_rst_n  = conv_rst_n_q;
  assign bus.conv_tile   = tile_q;
  assign bus.conv_kernel = kernel_q;
endmodule

// File: tb/tb_conv_tile_scheduler.sv
// tb/tb_conv_tile_scheduler.sv - scoreboard bench for conv_tile_scheduler with memory and engine models
module tb_conv_tile_scheduler;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_tile_scheduler_if #(.ADDR_W(AW)) bus();
  conv_tile_scheduler #(.IMG_W(10), .IMG_H(10), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed { logic [15:0] addr; logic [15:0] data; } wr_t;

  logic [7:0]  mem  [0:65535];
  logic [15:0] wmem [0:65535];
  logic [7:0]  img  [0:99];
  logic [7:0]  kern [0:8];
  wr_t         sb_q [$];
  wr_t         exp_w;
  bit          sb_en = 1'b1;
  int          pass_cnt = 0, total_cnt = 0;
  int          rd_cnt = 0, wr_cnt = 0, start_cnt = 0, done_cnt = 0, acc_cnt = 0, rdhi_cnt = 0;
  int          eng_lat = 4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total_cnt++;
    if (act === exp_v) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
  endtask

  function automatic logic [15:0][15:0] conv_ref(input logic [35:0][7:0] t, input logic [8:0][7:0] k);
    logic [15:0][15:0] res;
    logic [15:0] s;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        s = '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            s = s + 16'(t[(r + i) * 6 + c + j]) * 16'(k[i * 3 + j]);
        res[r * 4 + c] = s;
      end
    return res;
  endfunction

  function automatic logic [15:0] ref_out(input int y, input int x);
    logic [15:0] s = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s = s + 16'(img[(y + i) * 10 + x + j]) * 16'(kern[i * 3 + j]);
    return s;
  endfunction

  // memory: registered read, one cycle latency
  always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

  // engine: accumulates into its result registers until its reset is asserted
  logic [15:0][15:0] acc, res_q;
  logic eng_busy, eng_done;
  int   eng_left;
  assign bus.conv_c    = acc;
  assign bus.conv_done = eng_done;
  always @(posedge clk) begin
    if (!bus.conv_rst_n) begin
      acc <= '0; res_q <= '0; eng_done <= 1'b0; eng_busy <= 1'b0; eng_left <= 0;
    end else if (bus.conv_start) begin
      res_q <= conv_ref(bus.conv_tile, bus.conv_kernel);
      eng_busy <= 1'b1; eng_left <= eng_lat;
    end else if (eng_busy) begin
      if (eng_left == 0) begin
        for (int i = 0; i < 16; i++) acc[i] <= acc[i] + res_q[i];
        eng_done <= 1'b1; eng_busy <= 1'b0;
      end else eng_left <= eng_left - 1;
    end
  end

  always @(negedge clk) begin
    if (bus.rd_en) rd_cnt++;
    if (bus.rd_en && bus.conv_rst_n) rdhi_cnt++;
    if (bus.conv_start) start_cnt++;
    if (bus.job_done) done_cnt++;
    if (bus.cmd_valid && bus.cmd_ready) acc_cnt++;
    if (bus.wr_en) begin
      wr_cnt++;
      wmem[bus.wr_addr] = bus.wr_data;
      if (sb_en) begin
        if (sb_q.size() == 0) chk("unexpected_write", 32'(bus.wr_addr), 32'hFFFF_FFFF);
        else begin
          exp_w = sb_q.pop_front();
          chk("wr_addr", 32'(bus.wr_addr), 32'(exp_w.addr));
          chk("wr_data", 32'(bus.wr_data), 32'(exp_w.data));
        end
      end
    end
  end

  task automatic load_mem(input logic [15:0] in_b, input logic [15:0] k_b);
    for (int i = 0; i < 100; i++) mem[16'(in_b + 16'(i))] = img[i];
    for (int i = 0; i < 9; i++) mem[16'(k_b + 16'(i))] = kern[i];
  endtask

  task automatic push_exp(input logic [15:0] out_b, input int n_tiles);
    wr_t w;
    for (int t = 0; t < n_tiles; t++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          w.addr = 16'(out_b + 16'((4 * (t / 2) + r) * 8 + 4 * (t % 2) + c));
          w.data = ref_out(4 * (t / 2) + r, 4 * (t % 2) + c);
          sb_q.push_back(w);
        end
  endtask

  task automatic issue(input logic [15:0] in_b, input logic [15:0] k_b, input logic [15:0] out_b, input bit hold);
    @(posedge clk); #2;
    bus.cmd_in_base = in_b; bus.cmd_k_base = k_b; bus.cmd_out_base = out_b;
    bus.cmd_valid = 1'b1;
    if (!hold) begin
      @(posedge clk); #2;
      bus.cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input bit hold);
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.job_done && n < 5000);
    if (n >= 5000) chk("job_done_timeout", 0, 1);
    if (hold) begin @(posedge clk); #2; bus.cmd_valid = 1'b0; end
    repeat (3) @(negedge clk);
  endtask

  int rd0, wr0, st0, dn0, ac0, rh0, n;

  task automatic snap();
    rd0 = rd_cnt; wr0 = wr_cnt; st0 = start_cnt; dn0 = done_cnt; ac0 = acc_cnt; rh0 = rdhi_cnt;
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.abort = 1'b0;
    bus.cmd_in_base = '0; bus.cmd_k_base = '0; bus.cmd_out_base = '0;
    for (int i = 0; i < 65536; i++) begin mem[i] = '0; wmem[i] = '0; end

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_strobes", 32'({bus.rd_en, bus.wr_en, bus.conv_start, bus.job_done}), 0);
    chk("rst_conv_rst_n", 32'(bus.conv_rst_n), 0);
    chk("rst_regs", 32'((|bus.conv_tile) | (|bus.conv_kernel)), 0);
    @(posedge clk); #2; rst = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", 32'(bus.cmd_ready), 1);
    @(posedge clk); #2; bus.abort = 1'b1;
    @(posedge clk); #2; bus.abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_ignored", 32'({bus.busy, bus.cmd_ready}), 1);

    // job 1: ramp image, all-ones kernel
    for (int i = 0; i < 100; i++) img[i] = 8'((i / 10) * 10 + i % 10);
    for (int i = 0; i < 9; i++) kern[i] = 8'd1;
    load_mem(16'h0100, 16'h0080);
    push_exp(16'h1000, 4);
    snap();
    issue(16'h0100, 16'h0080, 16'h1000, 1'b0);
    wait_done(1'b0);
    chk("j1_rd_pulses", 32'(rd_cnt - rd0), 153);
    chk("j1_wr_pulses", 32'(wr_cnt - wr0), 64);
    chk("j1_starts", 32'(start_cnt - st0), 4);
    chk("j1_job_done", 32'(done_cnt - dn0), 1);
    chk("j1_engine_held_during_load", 32'(rdhi_cnt - rh0), 0);
    chk("j1_sb_empty", 32'(sb_q.size()), 0);
    chk("j1_out00", 32'(wmem[16'h1000]), 99);
    chk("j1_out77", 32'(wmem[16'h1000 + 63]), 792);

    // job 2: centre-tap kernel on random pixels, input base wraps past 0xFFFF
    for (int i = 0; i < 100; i++) img[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 9; i++) kern[i] = (i == 4) ? 8'd1 : 8'd0;
    eng_lat = 7;
    load_mem(16'hFFF0, 16'h0200);
    push_exp(16'h3000, 4);
    snap();
    issue(16'hFFF0, 16'h0200, 16'h3000, 1'b0);
    wait_done(1'b0);
    chk("j2_sb_empty", 32'(sb_q.size()), 0);
    chk("j2_out_first", 32'(wmem[16'h3000]), 32'(img[11]));
    chk("j2_out_last", 32'(wmem[16'h3000 + 63]), 32'(img[88]));

    // job 3: abort five cycles into the second tile's wait
    for (int i = 0; i < 100; i++) img[i] = 8'(i);
    for (int i = 0; i < 9; i++) kern[i] = 8'd1;
    eng_lat = 20;
    load_mem(16'h0400, 16'h0500);
    push_exp(16'h6000, 1);
    snap();
    issue(16'h0400, 16'h0500, 16'h6000, 1'b0);
    n = 0;
    for (int seen = 0; seen < 2 && n < 2000; n++) begin
      @(negedge clk);
      if (bus.conv_start) seen++;
    end
    if (n >= 2000) chk("j3_start_timeout", 0, 1);
    repeat (5) @(posedge clk);
    #2 bus.abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("j3_busy_after_abort", 32'(bus.busy), 0);
    chk("j3_quiet_after_abort", 32'({bus.rd_en, bus.wr_en, bus.conv_start, bus.conv_rst_n}), 0);
    bus.abort = 1'b0;
    repeat (40) @(negedge clk);
    chk("j3_writes", 32'(wr_cnt - wr0), 16);
    chk("j3_no_job_done", 32'(done_cnt - dn0), 0);
    chk("j3_sb_empty", 32'(sb_q.size()), 0);

    // job 4: fresh job after abort
    eng_lat = 3;
    push_exp(16'h6000, 4);
    issue(16'h0400, 16'h0500, 16'h6000, 1'b0);
    wait_done(1'b0);
    chk("j4_sb_empty", 32'(sb_q.size()), 0);

    // job 5: cmd_valid held high for the whole job, then job 6 back-to-back with new bases
    snap();
    push_exp(16'h7000, 4);
    issue(16'h0400, 16'h0500, 16'h7000, 1'b1);
    wait_done(1'b1);
    chk("j5_accepts", 32'(acc_cnt - ac0), 1);
    chk("j5_writes", 32'(wr_cnt - wr0), 64);
    for (int i = 0; i < 9; i++) kern[i] = 8'(i + 1);
    load_mem(16'h4000, 16'h4100);
    push_exp(16'h5000, 4);
    issue(16'h4000, 16'h4100, 16'h5000, 1'b0);
    wait_done(1'b0);
    chk("j6_sb_empty", 32'(sb_q.size()), 0);
    chk("j6_job_done", 32'(done_cnt - dn0), 2);

    // reset in the middle of a store burst
    sb_en = 1'b0;
    issue(16'h4000, 16'h4100, 16'h5000, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.wr_en && n < 2000);
    if (n >= 2000) chk("rst_store_timeout", 0, 1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_outputs", 32'({bus.busy, bus.wr_en, bus.rd_en, bus.conv_start, bus.job_done, bus.cmd_ready}), 0);
    chk("midrst_conv_rst_n", 32'(bus.conv_rst_n), 0);
    chk("midrst_wr_addr", 32'(bus.wr_addr), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("after_rst_cmd_ready", 32'(bus.cmd_ready), 1);
    chk("after_rst_idle", 32'({bus.busy, bus.conv_rst_n}), 0);
    sb_en = 1'b1;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
